itransform_sched: RTL and testbench

- Sequences one macroblock's 4x4 sub-blocks through the 2-cycle inverse-transform core (start -> done, one block accepted per cycle, no stall input).
- Issues one sub-block per cycle in index order. Blocks flagged all-zero are not sent to the core; they are marked for reference bypass instead.
- Drives the write-back path with index and bypass flag, aligned to core latency, and signals macroblock completion.
- Sits between the macroblock controller (start/mask/hold) and the core plus reconstruction writer.

---
 rtl/itransform_sched.sv | 133 +++++++++++++
 tb/tb_itransform_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itransform_sched.sv
// Issues a macroblock's 4x4 sub-blocks to the inverse-transform core in index order,
// routes all-zero blocks to reference bypass and lines write-back up with core latency.
module itransform_sched #(
    parameter int NUM_BLK = 16,
    parameter int IDX_W   = 5,
    parameter int LAT     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_BLK-1:0] nz_mask,
    input  logic               hold,
    output logic               it_start,
    output logic [IDX_W-1:0]   it_idx,
    input  logic               it_done,
    output logic               wr_en,
    output logic [IDX_W-1:0]   wr_idx,
    output logic               wr_bypass,
    output logic               busy,
    output logic               mb_done,
    output logic               sync_err
);

    localparam int               MASK_W   = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLK - 1);
    localparam logic [LAT-1:0]   EXIT_BIT = LAT'(1) << (LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [NUM_BLK-1:0] mask;
    logic [MASK_W-1:0]  mask_ext;
    logic               issue;
    logic               last_blk;
    logic               cur_nz;
    logic               pipe_drained;
    logic               exit_core;
    logic               mismatch;
    logic               sync_q;
    logic [LAT-1:0]     pipe_valid;
    logic [LAT-1:0]     pipe_skip;
    logic [IDX_W-1:0]   pipe_idx [LAT];

    // Mask is zero-extended to the full index range so any idx value selects a defined bit.
    assign mask_ext     = MASK_W'(mask);
    assign issue        = (state == S_ISSUE) && !hold;
    assign last_blk     = (idx == LAST_IDX);
    assign cur_nz       = mask_ext[idx];
    assign pipe_drained = ((pipe_valid & ~EXIT_BIT) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: if (issue && last_blk) state_nxt = S_DRAIN;
            S_DRAIN: if (pipe_drained) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        it_start = issue && cur_nz;
        busy     = (state != S_IDLE);
        mb_done  = (state == S_DONE);
    end

    // The counter stops on the last block so it_idx keeps showing it after the issue phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            mask <= '0;
        end else if (state == S_IDLE && start) begin
            idx  <= '0;
            mask <= nz_mask;
        end else if (issue && !last_blk) begin
            idx <= idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            pipe_skip  <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_skip[0]  <= issue && !cur_nz;
            pipe_idx[0]   <= idx;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_skip[i]  <= pipe_skip[i-1];
                pipe_idx[i]   <= pipe_idx[i-1];
            end
        end
    end

    assign it_idx    = idx;
    assign wr_en     = pipe_valid[LAT-1];
    assign wr_idx    = pipe_idx[LAT-1];
    assign wr_bypass = pipe_skip[LAT-1];

    // A done strobe must land exactly on each core-bound write slot; any disagreement latches.
    assign exit_core = pipe_valid[LAT-1] && !pipe_skip[LAT-1];
    assign mismatch  = it_done ^ exit_core;
    assign sync_err  = sync_q | mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
        end else if (mismatch) begin
            sync_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_itransform_sched.sv
// Randomized and directed bench for itransform_sched, checked every cycle against an
// event-schedule model of the macroblock sequence.
module tb_itransform_sched;

    localparam int NUM_BLK = 16;
    localparam int IDX_W   = 5;
    localparam int LAT     = 2;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [NUM_BLK-1:0] nz_mask;
    logic               hold;
    logic               it_start;
    logic [IDX_W-1:0]   it_idx;
    logic               it_done;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_bypass;
    logic               busy;
    logic               mb_done;
    logic               sync_err;

    itransform_sched #(.NUM_BLK(NUM_BLK), .IDX_W(IDX_W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .nz_mask   (nz_mask),
        .hold      (hold),
        .it_start  (it_start),
        .it_idx    (it_idx),
        .it_done   (it_done),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_bypass (wr_bypass),
        .busy      (busy),
        .mb_done   (mb_done),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: echoes each start LAT cycles later, optionally dropping one block index.
    logic     fault_en;
    int       fault_idx;
    logic [LAT-1:0] core_pipe;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) core_pipe <= '0;
        else core_pipe <= {core_pipe[LAT-2:0], it_start && !(fault_en && int'(it_idx) == fault_idx)};
    end
    assign it_done = core_pipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state: expected writes are scheduled by absolute cycle when a block is issued.
    bit                 m_active;
    bit                 m_sticky;
    int                 m_next;
    int                 m_idx;
    int                 m_done_cyc;
    logic [NUM_BLK-1:0] m_mask;
    int                 sched_idx [int];
    bit                 sched_skip [int];

    int iss_c[$], iss_i[$], wr_c[$], wr_b[$], done_c[$], serr_c[$], bfall_c[$];
    bit prev_serr, prev_busy;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active   = 0;
        m_sticky   = 0;
        m_next     = 0;
        m_idx      = 0;
        m_done_cyc = -1;
        sched_idx.delete();
        sched_skip.delete();
    endtask

    task automatic tick();
        bit issuing, accept, exp_wr, exp_skip, exp_done, exp_serr, mism, exp_start;
        int exp_widx;
        @(negedge clk);
        if (!rst_n) begin
            model_reset();
            checkOutput("rst_it_start", int'(it_start), 0);
            checkOutput("rst_it_idx", int'(it_idx), 0);
            checkOutput("rst_wr_en", int'(wr_en), 0);
            checkOutput("rst_wr_idx", int'(wr_idx), 0);
            checkOutput("rst_wr_bypass", int'(wr_bypass), 0);
            checkOutput("rst_busy", int'(busy), 0);
            checkOutput("rst_mb_done", int'(mb_done), 0);
            checkOutput("rst_sync_err", int'(sync_err), 0);
        end else begin
            issuing   = m_active && (m_next < NUM_BLK) && !hold;
            exp_start = issuing && (((m_mask >> m_next) & 1) != 0);
            exp_wr    = sched_idx.exists(cyc);
            exp_widx  = 0;
            exp_skip  = 0;
            if (exp_wr) begin
                exp_widx = sched_idx[cyc];
                exp_skip = sched_skip[cyc];
                sched_idx.delete(cyc);
                sched_skip.delete(cyc);
            end
            exp_done = m_active && (cyc == m_done_cyc);
            mism     = (it_done == 1'b1) != (exp_wr && !exp_skip);
            exp_serr = m_sticky || mism;
            m_sticky = exp_serr;

            checkOutput("busy", int'(busy), int'(m_active));
            checkOutput("it_start", int'(it_start), int'(exp_start));
            checkOutput("it_idx", int'(it_idx), m_idx);
            checkOutput("wr_en", int'(wr_en), int'(exp_wr));
            if (exp_wr) begin
                checkOutput("wr_idx", int'(wr_idx), exp_widx);
                checkOutput("wr_bypass", int'(wr_bypass), int'(exp_skip));
            end
            checkOutput("mb_done", int'(mb_done), int'(exp_done));
            checkOutput("sync_err", int'(sync_err), int'(exp_serr));

            accept = !m_active && start;
            if (issuing) begin
                sched_idx[cyc + LAT]  = m_next;
                sched_skip[cyc + LAT] = (((m_mask >> m_next) & 1) == 0);
                if (m_next < NUM_BLK - 1) m_idx = m_next + 1;
                m_next++;
                if (m_next == NUM_BLK) m_done_cyc = cyc + LAT + 1;
            end
            if (exp_done) m_active = 0;
            if (accept) begin
                m_active   = 1;
                m_next     = 0;
                m_idx      = 0;
                m_mask     = nz_mask;
                m_done_cyc = -1;
            end
        end
        if (it_start) begin iss_c.push_back(cyc); iss_i.push_back(int'(it_idx)); end
        if (wr_en) begin wr_c.push_back(cyc); wr_b.push_back(int'(wr_bypass)); end
        if (mb_done) done_c.push_back(cyc);
        if (sync_err && !prev_serr) serr_c.push_back(cyc);
        if (!busy && prev_busy) bfall_c.push_back(cyc);
        prev_serr = sync_err;
        prev_busy = busy;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int cnt_in(input int qc[$], input int lo, input int hi);
        int n = 0;
        foreach (qc[i]) if (qc[i] >= lo && qc[i] <= hi) n++;
        return n;
    endfunction

    function automatic int first_in(input int qc[$], input int lo, input int hi);
        foreach (qc[i]) if (qc[i] >= lo && qc[i] <= hi) return qc[i];
        return -1;
    endfunction

    function automatic int issue_cycle_of(input int idx, input int lo);
        foreach (iss_c[i]) if (iss_c[i] >= lo && iss_i[i] == idx) return iss_c[i];
        return -1;
    endfunction

    function automatic int idx_issued_at(input int c);
        foreach (iss_c[i]) if (iss_c[i] == c) return iss_i[i];
        return -1;
    endfunction

    function automatic int bypass_cnt(input int lo, input int hi);
        int n = 0;
        foreach (wr_c[i]) if (wr_c[i] >= lo && wr_c[i] <= hi && wr_b[i] == 1) n++;
        return n;
    endfunction

    function automatic int odd_issue_cnt(input int lo, input int hi);
        int n = 0;
        foreach (iss_c[i]) if (iss_c[i] >= lo && iss_c[i] <= hi && iss_i[i] % 2 == 1) n++;
        return n;
    endfunction

    // Relative cycle c: start at 0 (plus optional extra starts), hold in [hlo,hhi], rst low at ra..ra+1.
    task automatic applyStimulus(input logic [NUM_BLK-1:0] mask, input int hlo, input int hhi,
                                 input int sa, input int sb, input int ra, input int flt,
                                 input int ncyc, output int t0);
        t0        = cyc;
        fault_en  = (flt >= 0);
        fault_idx = flt;
        for (int c = 0; c < ncyc; c++) begin
            start   = (c == 0) || (c == sa) || (c == sb);
            hold    = (c >= hlo) && (c <= hhi);
            rst_n   = !((c == ra) || (c == ra + 1));
            nz_mask = (c == 0) ? mask : NUM_BLK'($urandom);
            tick();
        end
        start    = 1'b0;
        hold     = 1'b0;
        rst_n    = 1'b1;
        fault_en = 1'b0;
    endtask

    task automatic reset_cycles(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int t0, t1, w;
        rst_n     = 1'b0;
        start     = 1'b0;
        hold      = 1'b0;
        nz_mask   = '0;
        fault_en  = 1'b0;
        fault_idx = 0;
        prev_serr = 1'b0;
        prev_busy = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_cycles(3);
        tick();

        $display("[TB] all blocks nonzero");
        applyStimulus(16'hFFFF, -1, -2, -1, -1, -10, -1, 22, t0);
        checkOutput("full_first_issue", first_in(iss_c, t0, t0 + 21), t0 + 1);
        checkOutput("full_issue_cnt", cnt_in(iss_c, t0, t0 + 21), 16);
        checkOutput("full_last_issue_idx", idx_issued_at(t0 + 16), 15);
        checkOutput("full_first_wr", first_in(wr_c, t0, t0 + 21), t0 + 3);
        checkOutput("full_wr_cnt", cnt_in(wr_c, t0 + 3, t0 + 18), 16);
        checkOutput("full_bypass_cnt", bypass_cnt(t0, t0 + 21), 0);
        checkOutput("full_mb_done", first_in(done_c, t0, t0 + 21), t0 + 19);
        checkOutput("full_busy_fall", first_in(bfall_c, t0, t0 + 21), t0 + 20);
        checkOutput("full_sync_err", int'(sync_err), 0);

        $display("[TB] all blocks zero");
        applyStimulus(16'h0000, -1, -2, -1, -1, -10, -1, 22, t0);
        checkOutput("zero_issue_cnt", cnt_in(iss_c, t0, t0 + 21), 0);
        checkOutput("zero_wr_cnt", cnt_in(wr_c, t0, t0 + 21), 16);
        checkOutput("zero_bypass_cnt", bypass_cnt(t0, t0 + 21), 16);
        checkOutput("zero_mb_done", first_in(done_c, t0, t0 + 21), t0 + 19);

        $display("[TB] mixed mask with hold");
        applyStimulus(16'hAAAA, 4, 6, -1, -1, -10, -1, 25, t0);
        checkOutput("mix_issue_cnt", cnt_in(iss_c, t0, t0 + 24), 8);
        checkOutput("mix_odd_issues", odd_issue_cnt(t0, t0 + 24), 8);
        checkOutput("mix_idx3_cycle", issue_cycle_of(3, t0), t0 + 7);
        checkOutput("mix_mb_done", first_in(done_c, t0, t0 + 24), t0 + 22);
        checkOutput("mix_bypass_cnt", bypass_cnt(t0, t0 + 24), 8);
        checkOutput("mix_first_wr_bypass", wr_b[wr_b.size() - 16], 1);
        checkOutput("mix_second_wr_bypass", wr_b[wr_b.size() - 15], 0);

        $display("[TB] start while busy");
        applyStimulus(16'hFFFF, -1, -2, 5, 19, -10, -1, 20, t0);
        applyStimulus(16'h0F0F, -1, -2, -1, -1, -10, -1, 22, t1);
        checkOutput("ign_done_cnt", cnt_in(done_c, t0, t0 + 19), 1);
        checkOutput("ign_mb_done", first_in(done_c, t0, t0 + 19), t0 + 19);
        checkOutput("ign_wr_cnt", cnt_in(wr_c, t0, t0 + 19), 16);
        checkOutput("relaunch_first_issue", first_in(iss_c, t1, t1 + 21), t0 + 21);
        checkOutput("relaunch_mb_done", first_in(done_c, t1, t1 + 21), t1 + 19);

        $display("[TB] reset mid-macroblock");
        applyStimulus(16'hFFFF, -1, -2, -1, -1, 8, -1, 35, t0);
        checkOutput("rst_no_wr_after", cnt_in(wr_c, t0 + 8, t0 + 34), 0);
        checkOutput("rst_no_done_after", cnt_in(done_c, t0, t0 + 34), 0);
        applyStimulus(16'hFFFF, -1, -2, -1, -1, -10, -1, 22, t0);
        checkOutput("rst_rerun_wr_cnt", cnt_in(wr_c, t0, t0 + 21), 16);
        checkOutput("rst_rerun_mb_done", first_in(done_c, t0, t0 + 21), t0 + 19);

        $display("[TB] sync fault on block 5");
        applyStimulus(16'hFFFF, -1, -2, -1, -1, -10, 5, 26, t0);
        checkOutput("flt_serr_rise", first_in(serr_c, t0, t0 + 25), t0 + 8);
        checkOutput("flt_mb_done", first_in(done_c, t0, t0 + 25), t0 + 19);
        checkOutput("flt_serr_sticky", int'(sync_err), 1);
        reset_cycles(2);
        tick();
        checkOutput("flt_serr_cleared", int'(sync_err), 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) begin
                fault_en  = ($urandom_range(0, 3) == 0);
                fault_idx = $urandom_range(0, NUM_BLK - 1);
            end
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 3) == 0);
            w     = $urandom_range(0, 3);
            nz_mask = (w == 0) ? '0 : (w == 1) ? '1 : NUM_BLK'($urandom);
            tick();
        end
        start = 1'b0;
        hold  = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
